// File: rtl/uart_frame_writer.sv
// rtl/uart_frame_writer.sv - UART byte stream to RAM frame writer with header skip and word packing
module uart_frame_writer #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 18,
    parameter int DEPTH      = 262144,
    parameter int HEADER_LEN = 15,
    parameter int OVF_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_tick,
    input  logic [7:0]        rx_data,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              fin,
    output logic [OVF_W-1:0]  ovf_cnt
);

    localparam int BPW = DATA_W / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int HW  = (HEADER_LEN > 0) ? $clog2(HEADER_LEN + 1) : 1;
    localparam int WW  = ADDR_W + 1;

    localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);
    localparam logic [HW-1:0] LAST_HDR  = HW'((HEADER_LEN > 0) ? HEADER_LEN - 1 : 0);
    localparam logic [WW-1:0] LAST_WORD = WW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, HEADER, STORE, DONE} state_t;

    localparam state_t ARM_STATE = (HEADER_LEN == 0) ? STORE : HEADER;

    state_t             state_q, state_d;
    logic [HW-1:0]      hdr_cnt_q, hdr_cnt_d;
    logic [BW-1:0]      byte_idx_q, byte_idx_d;
    logic [WW-1:0]      word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0]  pack_q, pack_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               wen_q, wen_d;
    logic               fin_q, fin_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic [DATA_W-1:0]  merged;
    logic               last_wen;

    // The word counter doubles as the write address; it advances the cycle after each wen.
    assign addr     = word_cnt_q[ADDR_W-1:0];
    assign wen      = wen_q;
    assign dout     = dout_q;
    assign fin      = fin_q;
    assign ovf_cnt  = ovf_q;
    assign busy     = (state_q == HEADER) || (state_q == STORE);
    assign last_wen = wen_q && (word_cnt_q == LAST_WORD);

    always_comb begin
        merged = pack_q;
        for (int i = 0; i < BPW; i++) begin
            if (byte_idx_q == BW'(i)) begin
                merged[i*8 +: 8] = rx_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        dout_d     = dout_q;
        wen_d      = 1'b0;
        fin_d      = fin_q;
        ovf_d      = ovf_q;

        if (start) begin
            state_d    = ARM_STATE;
            hdr_cnt_d  = '0;
            byte_idx_d = '0;
            word_cnt_d = '0;
            pack_d     = '0;
            fin_d      = 1'b0;
            ovf_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                HEADER: begin
                    if (rx_tick) begin
                        if (hdr_cnt_q == LAST_HDR) begin
                            hdr_cnt_d = '0;
                            state_d   = STORE;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + HW'(1);
                        end
                    end
                end
                STORE: begin
                    if (wen_q) begin
                        if (last_wen) begin
                            state_d    = DONE;
                            fin_d      = 1'b1;
                            word_cnt_d = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + WW'(1);
                        end
                    end
                    // Bytes arriving while the final word is being written belong to no frame.
                    if (rx_tick && !last_wen) begin
                        pack_d = merged;
                        if (byte_idx_q == LAST_BYTE) begin
                            byte_idx_d = '0;
                            wen_d      = 1'b1;
                            dout_d     = merged;
                        end else begin
                            byte_idx_d = byte_idx_q + BW'(1);
                        end
                    end
                end
                DONE: begin
                    if (rx_tick && (ovf_q != {OVF_W{1'b1}})) begin
                        ovf_d = ovf_q + OVF_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hdr_cnt_q  <= '0;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            dout_q     <= '0;
            wen_q      <= 1'b0;
            fin_q      <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            dout_q     <= dout_d;
            wen_q      <= wen_d;
            fin_q      <= fin_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_writer.sv
// tb/tb_uart_frame_writer.sv - scoreboard bench for uart_frame_writer in three configurations
module tb_uart_frame_writer;

    typedef struct {
        int          dut;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_w   [3];
    logic        rx_tick_w [3];
    logic [7:0]  rx_data_w [3];

    logic        wen_a, wen_b, wen_c;
    logic [3:0]  addr_a, addr_b, addr_c;
    logic [7:0]  dout_a, dout_c;
    logic [15:0] dout_b;
    logic        busy_a, busy_b, busy_c;
    logic        fin_a, fin_b, fin_c;
    logic [7:0]  ovf_a, ovf_b, ovf_c;

    logic        wen_w  [3];
    logic [3:0]  addr_w [3];
    logic [15:0] dout_w [3];

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_writer #(.DATA_W(8), .ADDR_W(4), .DEPTH(4), .HEADER_LEN(2), .OVF_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .rx_tick(rx_tick_w[0]), .rx_data(rx_data_w[0]),
        .wen(wen_a), .addr(addr_a), .dout(dout_a), .busy(busy_a), .fin(fin_a), .ovf_cnt(ovf_a));

    uart_frame_writer #(.DATA_W(16), .ADDR_W(4), .DEPTH(2), .HEADER_LEN(0), .OVF_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .rx_tick(rx_tick_w[1]), .rx_data(rx_data_w[1]),
        .wen(wen_b), .addr(addr_b), .dout(dout_b), .busy(busy_b), .fin(fin_b), .ovf_cnt(ovf_b));

    uart_frame_writer #(.DATA_W(8), .ADDR_W(4), .DEPTH(4), .HEADER_LEN(1), .OVF_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .rx_tick(rx_tick_w[2]), .rx_data(rx_data_w[2]),
        .wen(wen_c), .addr(addr_c), .dout(dout_c), .busy(busy_c), .fin(fin_c), .ovf_cnt(ovf_c));

    assign wen_w[0]  = wen_a;
    assign wen_w[1]  = wen_b;
    assign wen_w[2]  = wen_c;
    assign addr_w[0] = addr_a;
    assign addr_w[1] = addr_b;
    assign addr_w[2] = addr_c;
    assign dout_w[0] = {8'h00, dout_a};
    assign dout_w[1] = dout_b;
    assign dout_w[2] = {8'h00, dout_c};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int d, input logic [7:0] b);
        rx_tick_w[d] = 1'b1;
        rx_data_w[d] = b;
        next_cycle();
        rx_tick_w[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        start_w[d] = 1'b1;
        next_cycle();
        start_w[d] = 1'b0;
    endtask

    // Called right after the completing byte's edge: the write must be visible in this same cycle.
    task automatic push(input int d, input int a, input int w);
        sb.push_back('{d, 32'(a), 32'(w), cyc});
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (wen_w[d]) begin
                if (sb.size() == 0) begin
                    check("unexpected_wen_dut", d, 32'hFF);
                end else begin
                    e = sb.pop_front();
                    check("wr_dut", d, e.dut);
                    check("wr_addr", addr_w[d], e.addr);
                    check("wr_data", dout_w[d], e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_w[d]   = 1'b0;
            rx_tick_w[d] = 1'b0;
            rx_data_w[d] = 8'h00;
        end
        repeat (3) next_cycle();
        rst_n = 1'b1;

        check("rst_wen", wen_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_fin", fin_a, 0);
        check("rst_ovf", ovf_a, 0);

        // T1: header skip then four single-byte words
        tick(0, 8'h5A);
        check("idle_ignores_tick_busy", busy_a, 0);
        pulse_start(0);
        check("t1_busy_after_start", busy_a, 1);
        tick(0, 8'h11);
        tick(0, 8'h22);
        for (int i = 0; i < 4; i++) begin
            tick(0, 8'hA0 + 8'(i));
            push(0, i, 'hA0 + i);
        end
        check("t1_fin_not_on_last_wen", fin_a, 0);
        next_cycle();
        check("t1_fin", fin_a, 1);
        check("t1_busy_done", busy_a, 0);
        check("t1_addr_back_to_0", addr_a, 0);
        check("t1_all_written", sb.size(), 0);

        // T4: overflow counting while DONE
        repeat (3) tick(0, 8'hEE);
        check("t4_ovf_3", ovf_a, 3);
        repeat (297) tick(0, 8'hEE);
        check("t4_ovf_sat", ovf_a, 255);
        check("t4_fin_held", fin_a, 1);
        pulse_start(0);
        check("t4_start_clears_fin", fin_a, 0);
        check("t4_start_clears_ovf", ovf_a, 0);
        check("t4_start_busy", busy_a, 1);

        // T6: reset lands on the edge that would have launched a write
        tick(0, 8'h01);
        tick(0, 8'h02);
        tick(0, 8'hB0);
        push(0, 0, 'hB0);
        rst_n        = 1'b0;
        rx_tick_w[0] = 1'b1;
        rx_data_w[0] = 8'hB1;
        next_cycle();
        rx_tick_w[0] = 1'b0;
        check("t6_wen", wen_a, 0);
        check("t6_addr", addr_a, 0);
        check("t6_dout", dout_a, 0);
        check("t6_busy", busy_a, 0);
        check("t6_fin", fin_a, 0);
        check("t6_ovf", ovf_a, 0);
        rst_n = 1'b1;
        tick(0, 8'hC5);
        tick(0, 8'hC6);
        check("t6_stays_idle", busy_a, 0);
        check("t6_no_writes", sb.size(), 0);

        // T5: start and rx_tick together from IDLE, byte is dropped
        start_w[1]   = 1'b1;
        rx_tick_w[1] = 1'b1;
        rx_data_w[1] = 8'hEE;
        next_cycle();
        start_w[1]   = 1'b0;
        rx_tick_w[1] = 1'b0;
        check("t5_busy", busy_b, 1);
        tick(1, 8'h34);
        tick(1, 8'h12);
        push(1, 0, 'h1234);
        tick(1, 8'h78);
        tick(1, 8'h56);
        push(1, 1, 'h5678);
        next_cycle();
        check("t5_fin", fin_b, 1);

        // T2: 16-bit little-endian packing, back-to-back bytes
        pulse_start(1);
        check("t2_fin_cleared", fin_b, 0);
        tick(1, 8'h34);
        tick(1, 8'h12);
        push(1, 0, 'h1234);
        tick(1, 8'h78);
        tick(1, 8'h56);
        push(1, 1, 'h5678);
        next_cycle();
        check("t2_fin", fin_b, 1);
        check("t2_addr_back_to_0", addr_b, 0);
        check("t2_all_written", sb.size(), 0);

        // T3: restart mid-frame while a write is still on the bus
        pulse_start(2);
        tick(2, 8'h99);
        tick(2, 8'hC0);
        push(2, 0, 'hC0);
        tick(2, 8'hC1);
        push(2, 1, 'hC1);
        pulse_start(2);
        check("t3_addr_restart", addr_c, 0);
        check("t3_busy", busy_c, 1);
        tick(2, 8'h98);
        for (int i = 0; i < 4; i++) begin
            tick(2, 8'hD0 + 8'(i));
            push(2, i, 'hD0 + i);
        end
        next_cycle();
        check("t3_fin", fin_c, 1);
        check("t3_all_written", sb.size(), 0);

        repeat (2) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
